// File: rtl/prog_counter.sv
// Program counter and fetch sequencer for the 8-bit ISA core.
// Drives the instruction-memory address and sequences IDLE -> RUN -> DONE.
module prog_counter #(
  parameter int A  = 6,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          jump_en,
  input  logic [A-1:0]  jump_target,
  input  logic          branch_en,
  input  logic [A-1:0]  branch_off,
  input  logic          halt,
  output logic [A-1:0]  pc,
  output logic          running,
  output logic          done,
  output logic          fault,
  output logic [CW-1:0] cycles
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [A-1:0]  PC_LAST  = '1;
  localparam logic [CW-1:0] CYC_SAT  = '1;

  state_t              state;
  logic signed [A-1:0] branch_off_s;

  assign branch_off_s = branch_off;

  // Executed-cycle count sticks at all-ones instead of wrapping.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (c == CYC_SAT) ? c : c + CW'(1);
  endfunction

  // Sign-extended add, truncated back to the address width so that
  // branches wrap around the program space in either direction.
  function automatic logic [A-1:0] branch_add(input logic [A-1:0]        base,
                                              input logic signed [A-1:0] off);
    logic signed [A:0] sum;
    sum = $signed({1'b0, base}) + $signed({off[A-1], off});
    return sum[A-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pc      <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      fault   <= 1'b0;
      cycles  <= '0;
    end else begin
      case (state)
        IDLE: begin
          pc <= '0;
          if (start) begin
            state   <= RUN;
            running <= 1'b1;
            cycles  <= '0;
          end
        end

        RUN: begin
          cycles <= sat_inc(cycles);
          if (halt) begin
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b0;
          end else if (jump_en) begin
            pc <= jump_target;
          end else if (branch_en) begin
            pc <= branch_add(pc, branch_off_s);
          end else if (pc == PC_LAST) begin
            // Sequential step past the last word: stop with a fault, pc parked.
            state   <= DONE;
            running <= 1'b0;
            done    <= 1'b1;
            fault   <= 1'b1;
          end else begin
            pc <= pc + A'(1);
          end
        end

        DONE: begin
          if (start) begin
            state   <= RUN;
            pc      <= '0;
            running <= 1'b1;
            done    <= 1'b0;
            fault   <= 1'b0;
            cycles  <= '0;
          end
        end

        default: begin
          state   <= IDLE;
          pc      <= '0;
          running <= 1'b0;
          done    <= 1'b0;
          fault   <= 1'b0;
          cycles  <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/prog_counter.md
# prog_counter

Program counter and fetch sequencer for the 8-bit ISA core. Sits directly upstream of the 64-entry instruction memory: it drives the memory's instruction address every cycle and updates it from the control signals decoded from the instruction that comes back. It owns program start, sequential advance, absolute jumps, relative branches, halt, fall-off-end fault and an executed-cycle counter.

## Interface
- A, 6, address width; the program space is 2^A instructions (64).
- CW, 16, width of the executed-cycle counter.

- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; sampled on the rising edge of clk.
- start  in  1  single-cycle pulse that begins execution at address 0; honoured in IDLE and DONE only.
- jump_en  in  1  absolute jump request for the current instruction.
- jump_target  in  A  absolute destination address.
- branch_en  in  1  taken relative branch for the current instruction.
- branch_off  in  A  signed two's-complement offset added to the current pc.
- halt  in  1  the current instruction is a halt.
- pc  out  A  instruction address; drives the memory address input.
- running  out  1  high while in RUN; the instruction at pc is being executed this cycle.
- done  out  1  high in DONE.
- fault  out  1  high in DONE when the program fell off the end of memory.
- cycles  out  CW  number of RUN cycles since the last start; saturating.

## Operation
- States: IDLE, RUN, DONE. After reset: state IDLE, pc=0, running=0, done=0, fault=0, cycles=0.
- IDLE
  - pc holds 0.
  - start goes to RUN with pc=0 and cycles=0.
  - All other inputs are ignored.
- RUN
  - running=1. Each cycle executes exactly one instruction and chooses next-pc by fixed priority: halt > jump_en > branch_en > sequential.
  - halt: go to DONE. pc holds (stays on the halt instruction). fault=0.
  - jump_en: pc <= jump_target.
  - branch_en: pc <= (pc + sign-extended branch_off) mod 2^A. Wrap-around in either direction is legal and not a fault. An offset of 0 is a legal self-loop.
  - sequential: pc <= pc+1. If pc is 2^A-1, go to DONE instead, with fault=1 and pc holding at 2^A-1.
  - cycles increments by 1 for every RUN cycle, including the halting cycle. It saturates at 2^CW-1 and never wraps.
  - start is ignored in RUN.
- DONE
  - done=1. pc, fault and cycles all hold.
  - start goes to RUN with pc=0, cycles=0, fault=0.
- Simultaneous jump_en and branch_en: the jump wins. Simultaneous halt with either: halt wins.
- Reset in any state, including mid-RUN, overrides every other input and returns to the reset values on the next edge.

## Timing
- pc, running, done, fault and cycles are all registered. There are no combinational paths from inputs to outputs.
- The memory read is combinational, so the instruction at pc is available in the same cycle. The decoded jump_en, branch_en and halt for that instruction are sampled on the next rising edge.
- Throughput is one instruction per cycle, with no bubbles after taken jumps or branches.
- start in cycle t: running=1 and pc=0 from cycle t+1. The first instruction is executed in cycle t+1.
- halt sampled in cycle t: done=1 and running=0 from cycle t+1.
- cycles equals the number of instructions executed, including the halt.

## Test plan
- Reset and idle:
  - Assert reset mid-RUN at pc=9 -> next cycle pc=0, running=0, done=0, fault=0, cycles=0.
  - Then drive jump_en, branch_en and halt with no start -> pc stays 0 and the state stays IDLE.
- Sequential run with halt:
  - Pulse start, then assert halt when pc=5 -> pc sequence 0,1,2,3,4,5,5.
  - done=1 one cycle after halt is sampled, with cycles=6 and fault=0.
- Jump and branch, including priority:
  - At pc=2 with jump_en=1, jump_target=40 -> pc=40.
  - At pc=40 with branch_off=6'b111101 (-3) -> pc=37.
  - At pc=37 with jump_en=1, jump_target=10, and branch_en=1 -> pc=10.
- Branch wrap-around:
  - At pc=62 with branch_off=5 -> pc=3 with fault=0.
  - At pc=1 with branch_off=-2 -> pc=63.
- Fall off the end:
  - Jump to 62, then no further control -> pc=63, then DONE with fault=1, pc=63, done=1.
  - A following start -> pc=0, fault=0, cycles=0, running=1.
- Counter saturation:
  - Set CW=4 and run a self-loop (branch_off=0) for 20 cycles -> cycles stops at 15 and stays there.
  - A start issued during RUN has no effect.
